// File: rtl/ifft4_pkg.sv
// Shared types and helpers for the 4-point IFFT core.
// Scaling mode is selected by IFFT4_ROUND_EN (defined: round half up + saturate, undefined: truncate).
package ifft4_pkg;

  localparam int WIDTH = 32;
  localparam int HALF  = WIDTH / 2;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    STAGE1 = 2'd1,
    STAGE2 = 2'd2,
    UNLOAD = 2'd3
  } state_t;

  typedef struct packed {
    logic signed [HALF-1:0] re;
    logic signed [HALF-1:0] im;
  } cplx_t;

  // Divide a widened sum/difference by two back into sample precision.
  function automatic logic signed [HALF-1:0] half_scale(input logic signed [HALF:0] v);
`ifdef IFFT4_ROUND_EN
    logic [HALF+1:0] t;
    t = {v[HALF], v} + {{(HALF+1){1'b0}}, 1'b1};
    if (t[HALF+1] != t[HALF])
      return t[HALF+1] ? {1'b1, {(HALF-1){1'b0}}} : {1'b0, {(HALF-1){1'b1}}};
    return t[HALF:1];
`else
    return v[HALF:1];
`endif
  endfunction

endpackage

// File: rtl/ifft4_core_bfly.sv
// Radix-2 DIF butterfly: scaled sum and scaled difference, optionally rotating the difference by +j.
module ifft_bfly_dif
  import ifft4_pkg::*;
#(
  parameter bit ROTATE = 1'b0
) (
  input  cplx_t a,
  input  cplx_t b,
  output cplx_t sum,
  output cplx_t diff
);

  logic signed [HALF:0] sre, sim, dre, dim, rre, rim;

  // Rotation happens on the full-precision difference so -im cannot overflow.
  always_comb begin
    sre = (HALF+1)'(a.re) + (HALF+1)'(b.re);
    sim = (HALF+1)'(a.im) + (HALF+1)'(b.im);
    dre = (HALF+1)'(a.re) - (HALF+1)'(b.re);
    dim = (HALF+1)'(a.im) - (HALF+1)'(b.im);
    if (ROTATE) begin
      rre = -dim;
      rim = dre;
    end else begin
      rre = dre;
      rim = dim;
    end
    sum.re  = half_scale(sre);
    sum.im  = half_scale(sim);
    diff.re = half_scale(rre);
    diff.im = half_scale(rim);
  end

endmodule

// File: rtl/ifft4_core.sv
// 4-point inverse FFT: load four bins, two in-place butterfly stages, unload four time samples.
// Build with IFFT4_ROUND_EN defined for rounded/saturated scaling instead of truncation.
module ifft4_core
  import ifft4_pkg::*;
#(
  parameter int WIDTH = ifft4_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last
);

  state_t     state, next_state;
  logic [1:0] lcnt, ucnt;
  cplx_t      s [4];
  cplx_t      a0, a1, b0, b1, x0, x1, x2, x3;
  logic       accept, handshake;

  assign accept    = in_valid && (state == LOAD);
  assign handshake = out_ready && (state == UNLOAD);

  // Stage 1 pairs bins k and k+2; the odd pair carries the +j twiddle.
  ifft_bfly_dif #(.ROTATE(1'b0)) u_s1_even (.a(s[0]), .b(s[2]), .sum(a0), .diff(b0));
  ifft_bfly_dif #(.ROTATE(1'b1)) u_s1_odd  (.a(s[1]), .b(s[3]), .sum(a1), .diff(b1));
  ifft_bfly_dif #(.ROTATE(1'b0)) u_s2_a    (.a(s[0]), .b(s[1]), .sum(x0), .diff(x2));
  ifft_bfly_dif #(.ROTATE(1'b0)) u_s2_b    (.a(s[2]), .b(s[3]), .sum(x1), .diff(x3));

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        if (accept && lcnt == 2'd3) next_state = STAGE1;
      end
      STAGE1: next_state = STAGE2;
      STAGE2: next_state = UNLOAD;
      UNLOAD: begin
        out_valid = 1'b1;
        if (handshake && ucnt == 2'd3) next_state = LOAD;
      end
      default: next_state = LOAD;
    endcase
  end

  assign out_data = (state == UNLOAD) ? s[ucnt] : '0;
  assign out_last = (state == UNLOAD) && (ucnt == 2'd3);

  // Storage is reused in place: bins, then stage-1 results, then time samples in natural order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LOAD;
      lcnt  <= 2'd0;
      ucnt  <= 2'd0;
      for (int i = 0; i < 4; i++) s[i] <= '0;
    end else begin
      state <= next_state;
      case (state)
        LOAD: begin
          if (accept) begin
            s[lcnt] <= in_data;
            lcnt    <= lcnt + 2'd1;
          end
        end
        STAGE1: begin
          s[0] <= a0;
          s[1] <= a1;
          s[2] <= b0;
          s[3] <= b1;
        end
        STAGE2: begin
          s[0] <= x0;
          s[1] <= x1;
          s[2] <= x2;
          s[3] <= x3;
        end
        UNLOAD: begin
          if (handshake) ucnt <= ucnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ifft4_core.sv
// Directed self-checking bench for ifft4_core: vector table plus backpressure, back-to-back and reset sequences.
module tb_ifft4_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;

  int checks = 0;
  int fails  = 0;

  ifft4_core #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    string            name;
    logic [3:0][31:0] x;
    logic [3:0][31:0] y;
  } vec_t;

`ifdef IFFT4_ROUND_EN
  localparam logic [31:0] IMP_OUT = 32'h2000_0000;
  localparam logic [31:0] NEG_OUT = 32'h0000_0000;
`else
  localparam logic [31:0] IMP_OUT = 32'h1FFF_0000;
  localparam logic [31:0] NEG_OUT = 32'hFFFF_0000;
`endif

  function automatic logic [3:0][31:0] mk(input logic [31:0] a, b, c, d);
    logic [3:0][31:0] r;
    r[0] = a; r[1] = b; r[2] = c; r[3] = d;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    fails++;
    $display("[TB] FAIL %s: timed out waiting on DUT", name);
  endtask

  // Feeds four bins; returns at the sampling point just after X[3] was accepted.
  task automatic applyStimulus(input logic [3:0][31:0] frame, input bit hold_valid);
    int guard;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = frame[i];
      guard    = 0;
      while (!in_ready && guard < 100) begin
        @(posedge clk); #1;
        guard++;
      end
      if (guard >= 100) timeoutFail("in_ready wait");
      @(posedge clk); #1;
    end
    if (!hold_valid) in_valid = 1'b0;
    checkOutput("in_ready in STAGE1", {31'b0, in_ready}, 32'd0);
  endtask

  task automatic receiveRange(input logic [3:0][31:0] exp, input string tag,
                              input int first, input int lastn, input bit check_lat);
    int waited;
    out_ready = 1'b1;
    for (int n = first; n <= lastn; n++) begin
      waited = 0;
      while (!out_valid && waited < 100) begin
        @(posedge clk); #1;
        waited++;
      end
      if (waited >= 100) timeoutFail($sformatf("%s out_valid wait", tag));
      if (n == first && check_lat)
        checkOutput($sformatf("%s latency", tag), 32'(waited), 32'd2);
      checkOutput($sformatf("%s x%0d", tag, n), out_data, exp[n]);
      checkOutput($sformatf("%s last%0d", tag, n), {31'b0, out_last}, {31'b0, n == 3});
      checkOutput($sformatf("%s in_ready%0d", tag, n), {31'b0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
  endtask

  vec_t vecs [6];
  logic [3:0][31:0] dc_x, dc_y, bin1_x, bin1_y;

  initial begin
    dc_x   = mk(32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000);
    dc_y   = mk(32'h4000_0000, 32'h0, 32'h0, 32'h0);
    bin1_x = mk(32'h0, 32'h4000_0000, 32'h0, 32'h0);
    bin1_y = mk(32'h1000_0000, 32'h0000_1000, 32'hF000_0000, 32'h0000_F000);

    vecs[0] = '{"impulse", mk(32'h7FFF_0000, 0, 0, 0), mk(IMP_OUT, IMP_OUT, IMP_OUT, IMP_OUT)};
    vecs[1] = '{"dc",      dc_x,   dc_y};
    vecs[2] = '{"bin1",    bin1_x, bin1_y};
    vecs[3] = '{"bin3",    mk(0, 0, 0, 32'h4000_0000),
                mk(32'h1000_0000, 32'h0000_F000, 32'hF000_0000, 32'h0000_1000)};
    vecs[4] = '{"neg1",    mk(32'hFFFF_0000, 0, 0, 0), mk(NEG_OUT, NEG_OUT, NEG_OUT, NEG_OUT)};
    vecs[5] = '{"imag",    mk(32'h0000_4000, 0, 0, 0),
                mk(32'h0000_1000, 32'h0000_1000, 32'h0000_1000, 32'h0000_1000)};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset in_ready",  {31'b0, in_ready},  32'd1);
    checkOutput("reset out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("reset out_last",  {31'b0, out_last},  32'd0);
    checkOutput("reset out_data",  out_data,           32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < 6; v++) begin
      applyStimulus(vecs[v].x, 1'b0);
      receiveRange(vecs[v].y, vecs[v].name, 0, 3, 1'b1);
    end

    // Backpressure on x1 for five cycles.
    applyStimulus(bin1_x, 1'b0);
    receiveRange(bin1_y, "bp", 0, 0, 1'b1);
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      checkOutput($sformatf("bp hold data c%0d", c), out_data, bin1_y[1]);
      checkOutput($sformatf("bp hold valid c%0d", c), {31'b0, out_valid}, 32'd1);
      checkOutput($sformatf("bp in_ready c%0d", c), {31'b0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    receiveRange(bin1_y, "bp", 1, 3, 1'b0);

    // Back-to-back frames with in_valid held high throughout.
    applyStimulus(vecs[0].x, 1'b1);
    in_data = bin1_x[0];
    receiveRange(vecs[0].y, "b2b A", 0, 3, 1'b1);
    checkOutput("b2b in_ready after A", {31'b0, in_ready}, 32'd1);
    applyStimulus(bin1_x, 1'b0);
    receiveRange(bin1_y, "b2b B", 0, 3, 1'b1);

    // Reset during UNLOAD after x1 has been taken.
    applyStimulus(bin1_x, 1'b0);
    receiveRange(bin1_y, "rstU", 0, 1, 1'b1);
    rst = 1'b1;
    #1;
    checkOutput("rstU out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rstU in_ready",  {31'b0, in_ready},  32'd1);
    checkOutput("rstU out_data",  out_data,           32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    applyStimulus(dc_x, 1'b0);
    receiveRange(dc_y, "dc after rstU", 0, 3, 1'b1);

    // Reset after a partial load; the next sample must land as X[0].
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h1234_5678;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    applyStimulus(dc_x, 1'b0);
    receiveRange(dc_y, "dc after rstL", 0, 3, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
